// File: rtl/medidor_distancia_bcd_if.sv
// Handshake and result bundle between the echo-width meter and its neighbours.
// The master drives the start request, echo pulse and unit select; the slave returns the latched result.
interface medidor_distancia_bcd_if #(
    parameter int D = 3
);
    logic           medir;
    logic           pulso;
    logic           unidade;
    logic [4*D-1:0] digitos;
    logic           pronto;
    logic           ocupado;
    logic           estouro;
    logic           erro_timeout;
    logic [2:0]     db_estado;

    modport master (
        output medir, pulso, unidade,
        input  digitos, pronto, ocupado, estouro, erro_timeout, db_estado
    );

    modport slave (
        input  medir, pulso, unidade,
        output digitos, pronto, ocupado, estouro, erro_timeout, db_estado
    );
endinterface

// File: rtl/medidor_distancia_bcd.sv
// Echo-pulse width to D-digit BCD distance (cm or inch) with start/done handshake.
// Optional pulse/wait timeout enabled by defining MEDIDOR_TIMEOUT_EN.
module medidor_distancia_bcd #(
    parameter int R_CM    = 2941,
    parameter int R_IN    = 7462,
    parameter int D       = 3,
    parameter int TIMEOUT = 1250000
) (
    input  logic clock,
    input  logic reset,
    medidor_distancia_bcd_if.slave bus
);
    localparam int R_MAX = (R_CM > R_IN) ? R_CM : R_IN;
    localparam int TW    = (R_MAX > 1) ? $clog2(R_MAX) : 1;
    localparam int RW    = $clog2(R_MAX + 1);

    if (D < 1 || D > 6 || TIMEOUT < 1) begin : g_param_check
        $error("medidor_distancia_bcd: D must be 1..6 and TIMEOUT positive");
    end

    typedef enum logic [2:0] {
        INICIAL    = 3'b000,
        ESPERA     = 3'b001,
        CONTA      = 3'b010,
        ARMAZENA   = 3'b011,
`ifdef MEDIDOR_TIMEOUT_EN
        TIMEOUT_ST = 3'b101,
`endif
        FIM        = 3'b100
    } estado_t;

    estado_t        estado;
    logic [TW-1:0]  tick;
    logic [RW-1:0]  sel_r;
    logic [4*D-1:0] acc;
    logic           ovf;
    logic [4*D-1:0] digitos;
    logic           estouro;
    logic           pronto;
    logic           conta_ciclo;
    logic           no_meio;
    logic           fim_periodo;
    logic [4*D:0]   acc_inc;

    // Increment with saturation: all-9s stays all-9s and reports overflow in the MSB.
    function automatic logic [4*D:0] bcd_inc(input logic [4*D-1:0] v);
        logic [4*D-1:0] r;
        logic           carry;
        logic           all9;
        all9 = 1'b1;
        for (int i = 0; i < D; i++) begin
            if (v[4*i +: 4] != 4'd9) all9 = 1'b0;
        end
        r     = v;
        carry = 1'b1;
        if (!all9) begin
            for (int i = 0; i < D; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return {all9, r};
    endfunction

    // A pulse cycle counts in ESPERA too: the detection cycle is pulse cycle 0.
    assign conta_ciclo = bus.pulso && (estado == ESPERA || estado == CONTA);
    assign no_meio     = (RW'(tick) == (sel_r >> 1));
    assign fim_periodo = (RW'(tick) == sel_r - RW'(1));
    assign acc_inc     = bcd_inc(acc);

`ifdef MEDIDOR_TIMEOUT_EN
    localparam int MW = $clog2(TIMEOUT + 1);
    logic [MW-1:0] tmo_cnt;
    logic          erro_timeout;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= INICIAL;
            tick    <= '0;
            sel_r   <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            digitos <= '0;
            estouro <= 1'b0;
            pronto  <= 1'b0;
`ifdef MEDIDOR_TIMEOUT_EN
            tmo_cnt      <= '0;
            erro_timeout <= 1'b0;
`endif
        end else begin
            pronto <= 1'b0;

            if (conta_ciclo) begin
                tick <= fim_periodo ? '0 : tick + TW'(1);
                if (no_meio) begin
                    acc <= acc_inc[4*D-1:0];
                    if (acc_inc[4*D]) ovf <= 1'b1;
                end
            end

            case (estado)
                INICIAL: begin
                    if (bus.medir) begin
                        tick    <= '0;
                        acc     <= '0;
                        ovf     <= 1'b0;
                        estouro <= 1'b0;
                        sel_r   <= bus.unidade ? RW'(R_IN) : RW'(R_CM);
`ifdef MEDIDOR_TIMEOUT_EN
                        tmo_cnt      <= '0;
                        erro_timeout <= 1'b0;
`endif
                        estado  <= ESPERA;
                    end
                end
                ESPERA:   if (bus.pulso) estado <= CONTA;
                CONTA:    if (!bus.pulso) estado <= ARMAZENA;
                ARMAZENA: begin
                    digitos <= acc;
                    estouro <= ovf;
                    pronto  <= 1'b1;
                    estado  <= FIM;
                end
`ifdef MEDIDOR_TIMEOUT_EN
                TIMEOUT_ST: begin
                    erro_timeout <= 1'b1;
                    pronto       <= 1'b1;
                    estado       <= FIM;
                end
`endif
                FIM:      estado <= INICIAL;
                default:  estado <= INICIAL;
            endcase

`ifdef MEDIDOR_TIMEOUT_EN
            // Timeout overrides any ESPERA/CONTA transition taken this cycle.
            if (estado == ESPERA || estado == CONTA) begin
                if (tmo_cnt == MW'(TIMEOUT - 1)) estado <= TIMEOUT_ST;
                else tmo_cnt <= tmo_cnt + MW'(1);
            end
`endif
        end
    end

    assign bus.digitos   = digitos;
    assign bus.estouro   = estouro;
    assign bus.pronto    = pronto;
    assign bus.ocupado   = (estado != INICIAL);
    assign bus.db_estado = estado;
`ifdef MEDIDOR_TIMEOUT_EN
    assign bus.erro_timeout = erro_timeout;
`else
    assign bus.erro_timeout = 1'b0;
`endif
endmodule
